// File: rtl/pc_gen_if.sv
// pc_gen_if: instruction-fetch request bus between the PC generator and
// instruction memory.
//
// Signals:
//   fetch_valid  - fetch request valid (driven by the PC generator)
//   fetch_pc     - fetch address (driven by the PC generator)
//   fetch_ready  - instruction memory accepts the request this cycle
//   fetch_is_rvc - fetched instruction is 16-bit (only meaningful with PC_RVC_EN)
//
// Modports:
//   master - PC generator side
//   slave  - instruction memory side
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid;
  logic [XLEN-1:0] fetch_pc;
  logic            fetch_ready;
  logic            fetch_is_rvc;

  modport master (
    output fetch_valid,
    output fetch_pc,
    input  fetch_ready,
    input  fetch_is_rvc
  );

  modport slave (
    input  fetch_valid,
    input  fetch_pc,
    output fetch_ready,
    output fetch_is_rvc
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the in-order RISC-V core.
//
// Holds the PC, applies trap/branch redirects in priority order, latches a
// redirect that arrives while the fetch is held so it is not lost, and runs a
// BOOT/RUN/HALT state machine that gates the fetch request.
//
// Optional feature macro: PC_RVC_EN
//   defined   - compressed support: increment is 2 or 4 (fetch_is_rvc),
//               targets are 2-byte aligned.
//   undefined - increment is always 4, targets are 4-byte aligned,
//               fetch_is_rvc is ignored.
//
// Ports:
//   clk            - core clock, rising edge
//   rst            - asynchronous active-high reset
//   stall          - per-source stall requests (any bit holds the PC)
//   redirect_valid - branch/jump redirect request
//   redirect_pc    - redirect target
//   trap_valid     - trap/interrupt redirect, highest priority
//   trap_vec       - trap target
//   halt_req       - request to stop fetching
//   resume         - leave the halted state
//   fetch          - fetch request bus (pc_gen_if.master)
//   current_pc     - registered PC
//   halted         - high while halted
//   misalign       - one-cycle pulse: last loaded target had dropped low bits
module pc_gen #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              NSTALL   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTALL-1:0] stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_vec,
  input  logic              halt_req,
  input  logic              resume,
  pc_gen_if.master          fetch,
  output logic [XLEN-1:0]   current_pc,
  output logic              halted,
  output logic              misalign
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

`ifdef PC_RVC_EN
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-1){1'b0}}, 1'b1};
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b0}}, 2'b11};
`endif

  // Target with the unsupported low bits cleared.
  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
    return t & ~ALIGN_MASK;
  endfunction

  // Target had low bits set that alignment drops.
  function automatic logic target_misaligned(input logic [XLEN-1:0] t);
    return (t & ALIGN_MASK) != {XLEN{1'b0}};
  endfunction

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pend_pc_r;
  logic            pend_valid_r;
  logic            misalign_r;
  logic            fetch_valid_r;
  logic            halted_r;

  logic            hold_s;
  logic [XLEN-1:0] inc_s;
  logic [XLEN-1:0] pc_inc_s;

  // Hold condition and sequential next-PC; the adder wraps modulo 2^XLEN.
  always_comb begin
    hold_s = (|stall) | ~fetch.fetch_ready;
`ifdef PC_RVC_EN
    if (fetch.fetch_is_rvc) begin
      inc_s = XLEN'(2);
    end else begin
      inc_s = XLEN'(4);
    end
`else
    inc_s = XLEN'(4);
`endif
    pc_inc_s = pc_r + inc_s;
  end

  // PC, pending-redirect latch and BOOT/RUN/HALT machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_PC;
      pend_pc_r     <= {XLEN{1'b0}};
      pend_valid_r  <= 1'b0;
      misalign_r    <= 1'b0;
      fetch_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      misalign_r <= 1'b0;
      case (state_r)
        ST_BOOT: begin
          state_r       <= ST_RUN;
          fetch_valid_r <= 1'b1;
          halted_r      <= 1'b0;
        end
        ST_RUN: begin
          if (trap_valid) begin
            // Trap wins over everything, including hold and halt_req.
            pc_r         <= align_target(trap_vec);
            misalign_r   <= target_misaligned(trap_vec);
            pend_valid_r <= 1'b0;
          end else if (hold_s) begin
            // Held: remember the newest redirect; halt_req waits.
            if (redirect_valid) begin
              pend_pc_r    <= redirect_pc;
              pend_valid_r <= 1'b1;
            end
          end else begin
            if (redirect_valid) begin
              pc_r       <= align_target(redirect_pc);
              misalign_r <= target_misaligned(redirect_pc);
            end else if (pend_valid_r) begin
              pc_r       <= align_target(pend_pc_r);
              misalign_r <= target_misaligned(pend_pc_r);
            end else begin
              pc_r <= pc_inc_s;
            end
            pend_valid_r <= 1'b0;
            if (halt_req) begin
              state_r       <= ST_HALT;
              fetch_valid_r <= 1'b0;
              halted_r      <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (trap_valid) begin
            pc_r          <= align_target(trap_vec);
            misalign_r    <= target_misaligned(trap_vec);
            pend_valid_r  <= 1'b0;
            state_r       <= ST_RUN;
            fetch_valid_r <= 1'b1;
            halted_r      <= 1'b0;
          end else begin
            // Redirects seen while halted are consumed after resume.
            if (redirect_valid) begin
              pend_pc_r    <= redirect_pc;
              pend_valid_r <= 1'b1;
            end
            if (resume) begin
              state_r       <= ST_RUN;
              fetch_valid_r <= 1'b1;
              halted_r      <= 1'b0;
            end
          end
        end
        default: begin
          // Unreachable encoding: fall back to a clean boot.
          state_r       <= ST_BOOT;
          pend_valid_r  <= 1'b0;
          fetch_valid_r <= 1'b0;
          halted_r      <= 1'b0;
        end
      endcase
    end
  end

  assign fetch.fetch_valid = fetch_valid_r;
  assign fetch.fetch_pc    = pc_r;
  assign current_pc        = pc_r;
  assign halted            = halted_r;
  assign misalign          = misalign_r;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: self-checking bench for pc_gen. Directed steps from the test
// plan followed by randomized cycles, all checked against a behavioural model.
module tb_pc_gen;
  localparam int          XLEN   = 32;
  localparam int          NSTALL = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef PC_RVC_EN
  localparam int unsigned UNIT = 2;
`else
  localparam int unsigned UNIT = 4;
`endif
  localparam int MODE_BOOT = 0;
  localparam int MODE_RUN  = 1;
  localparam int MODE_HALT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NSTALL-1:0] stall;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              trap_valid;
  logic [XLEN-1:0]   trap_vec;
  logic              halt_req;
  logic              resume;
  logic [XLEN-1:0]   current_pc;
  logic              halted;
  logic              misalign;

  pc_gen_if #(.XLEN(XLEN)) fetch_bus ();

  pc_gen #(.XLEN(XLEN), .RESET_PC(RST_PC), .NSTALL(NSTALL)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_vec       (trap_vec),
    .halt_req       (halt_req),
    .resume         (resume),
    .fetch          (fetch_bus),
    .current_pc     (current_pc),
    .halted         (halted),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model state
  bit [31:0] m_pc;
  bit [31:0] m_pend_pc;
  bit        m_pend;
  bit        m_mis;
  int        m_mode;

  task automatic model_reset();
    m_pc      = RST_PC;
    m_pend    = 1'b0;
    m_pend_pc = 32'h0;
    m_mis     = 1'b0;
    m_mode    = MODE_BOOT;
  endtask

  task automatic model_load(input bit [31:0] t);
    m_pc  = t - (t % UNIT);
    m_mis = (t % UNIT) != 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit held;
    int step;
    m_mis = 1'b0;
    held  = (stall != '0) || !fetch_bus.fetch_ready;
`ifdef PC_RVC_EN
    step = fetch_bus.fetch_is_rvc ? 2 : 4;
`else
    step = 4;
`endif
    if (m_mode == MODE_BOOT) begin
      m_mode = MODE_RUN;
    end else if (m_mode == MODE_RUN) begin
      if (trap_valid) begin
        model_load(trap_vec);
        m_pend = 1'b0;
      end else if (held) begin
        if (redirect_valid) begin
          m_pend    = 1'b1;
          m_pend_pc = redirect_pc;
        end
      end else begin
        if (redirect_valid) model_load(redirect_pc);
        else if (m_pend)    model_load(m_pend_pc);
        else                m_pc = m_pc + 32'(step);
        m_pend = 1'b0;
        if (halt_req) m_mode = MODE_HALT;
      end
    end else begin
      if (redirect_valid) begin
        m_pend    = 1'b1;
        m_pend_pc = redirect_pc;
      end
      if (trap_valid) begin
        model_load(trap_vec);
        m_pend = 1'b0;
        m_mode = MODE_RUN;
      end else if (resume) begin
        m_mode = MODE_RUN;
      end
    end
  endtask

  task automatic check(input string tag);
    compared++;
    assert (fetch_bus.fetch_valid === (m_mode == MODE_RUN)) else begin
      mismatched++;
      $error("FAIL %s fetch_valid: observed %b expected %b", tag, fetch_bus.fetch_valid, (m_mode == MODE_RUN));
    end
    compared++;
    assert (fetch_bus.fetch_pc === m_pc) else begin
      mismatched++;
      $error("FAIL %s fetch_pc: observed %h expected %h", tag, fetch_bus.fetch_pc, m_pc);
    end
    compared++;
    assert (current_pc === m_pc) else begin
      mismatched++;
      $error("FAIL %s current_pc: observed %h expected %h", tag, current_pc, m_pc);
    end
    compared++;
    assert (halted === (m_mode == MODE_HALT)) else begin
      mismatched++;
      $error("FAIL %s halted: observed %b expected %b", tag, halted, (m_mode == MODE_HALT));
    end
    compared++;
    assert (misalign === m_mis) else begin
      mismatched++;
      $error("FAIL %s misalign: observed %b expected %b", tag, misalign, m_mis);
    end
  endtask

  // Directed check of fetch_pc against a fixed test-plan value.
  task automatic chk_pc(input string tag, input logic [31:0] exp);
    compared++;
    assert (fetch_bus.fetch_pc === exp) else begin
      mismatched++;
      $error("FAIL %s: fetch_pc observed %h expected %h", tag, fetch_bus.fetch_pc, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    rst                    = 1'b1;
    stall                  = '0;
    redirect_valid         = 1'b0;
    redirect_pc            = '0;
    trap_valid             = 1'b0;
    trap_vec               = '0;
    halt_req               = 1'b0;
    resume                 = 1'b0;
    fetch_bus.fetch_ready  = 1'b1;
    fetch_bus.fetch_is_rvc = 1'b0;
    model_reset();

    // Reset and boot
    repeat (2) @(posedge clk);
    #1;
    check("reset");
    chk_pc("reset_pc", 32'h100);
    chk_bit("reset_fv", fetch_bus.fetch_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("boot");
    chk_bit("boot_fv", fetch_bus.fetch_valid, 1'b0);
    cycle("run0"); chk_pc("seq0", 32'h100); chk_bit("run_fv", fetch_bus.fetch_valid, 1'b1);
    cycle("run1"); chk_pc("seq1", 32'h104);

    // Redirect arriving during a stall is kept
    stall = 2'b10;
    cycle("stall1"); chk_pc("stall1", 32'h104);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cycle("stall2"); chk_pc("stall2", 32'h104);
    redirect_valid = 1'b0;
    cycle("stall3"); chk_pc("stall3", 32'h104);
    stall = 2'b00;
    cycle("pend_use"); chk_pc("pend_use", 32'h200);
    cycle("pend_inc"); chk_pc("pend_inc", 32'h204);

    // Trap beats redirect, stall and halt_req
    trap_valid = 1'b1; trap_vec = 32'h80;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    stall = 2'b01; halt_req = 1'b1;
    cycle("trap"); chk_pc("trap", 32'h80);
    chk_bit("trap_stays_run", fetch_bus.fetch_valid, 1'b1);
    trap_valid = 1'b0; redirect_valid = 1'b0; stall = 2'b00; halt_req = 1'b0;
    cycle("trap_nopend"); chk_pc("trap_nopend", 32'h84);

    // Halt and resume
    redirect_valid = 1'b1; redirect_pc = 32'h108;
    cycle("to108"); chk_pc("to108", 32'h108);
    redirect_valid = 1'b0; halt_req = 1'b1;
    cycle("halt"); chk_bit("halted", halted, 1'b1); chk_bit("halt_fv", fetch_bus.fetch_valid, 1'b0);
    halt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("halt_hold");
      chk_bit("halt_hold_fv", fetch_bus.fetch_valid, 1'b0);
    end
    resume = 1'b1;
    cycle("resume"); chk_pc("resume", 32'h10C); chk_bit("resume_fv", fetch_bus.fetch_valid, 1'b1);
    resume = 1'b0;
    cycle("after_resume"); chk_pc("after_resume", 32'h110);

    // Misaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    cycle("mis");
`ifdef PC_RVC_EN
    chk_pc("mis", 32'h202); chk_bit("mis_pulse", misalign, 1'b0);
`else
    chk_pc("mis", 32'h200); chk_bit("mis_pulse", misalign, 1'b1);
`endif
    redirect_valid = 1'b0; fetch_bus.fetch_is_rvc = 1'b1;
    cycle("mis_next"); chk_pc("mis_next", 32'h204); chk_bit("mis_once", misalign, 1'b0);
    fetch_bus.fetch_is_rvc = 1'b0;

    // Wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle("top"); chk_pc("top", 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    cycle("wrap"); chk_pc("wrap", 32'h0);

    // Asynchronous reset mid-stall with a pending redirect
    stall = 2'b01; redirect_valid = 1'b1; redirect_pc = 32'h500;
    cycle("pend_set");
    redirect_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst");
    chk_pc("async_rst", 32'h100);
    @(negedge clk);
    rst = 1'b0;
    cycle("rst_boot"); chk_pc("rst_boot", 32'h100);
    stall = 2'b00;
    cycle("rst_nopend"); chk_pc("rst_nopend", 32'h104);

    // Randomized cycles against the model
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check("rand_rst");
        #1;
        rst = 1'b0;
      end
      stall                  = ($urandom_range(0, 3) == 0) ? NSTALL'($urandom_range(1, 3)) : '0;
      redirect_valid         = ($urandom_range(0, 4) == 0);
      redirect_pc            = $urandom;
      trap_valid             = ($urandom_range(0, 15) == 0);
      trap_vec               = $urandom;
      halt_req               = ($urandom_range(0, 11) == 0);
      resume                 = ($urandom_range(0, 3) == 0);
      fetch_bus.fetch_ready  = ($urandom_range(0, 5) != 0);
      fetch_bus.fetch_is_rvc = ($urandom_range(0, 1) == 0);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the in-order RISC-V core, sitting between the hazard/branch logic and the instruction-fetch port. It supersedes the single hold-or-load PC register with the following features:
- configurable width, reset vector and number of stall sources;
- prioritised trap and branch redirects;
- a pending-redirect latch, so redirects arriving during a stall are not lost;
- a halt/resume state machine;
- a valid/ready request to instruction memory.

## Interface
- XLEN, 32, PC and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NSTALL, 2, number of independent stall sources (e.g. load-use, multiplier).
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  NSTALL  per-source stall requests; any bit high holds the PC.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  XLEN  redirect target.
- trap_valid  in  1  trap/interrupt redirect, highest priority.
- trap_vec  in  XLEN  trap target.
- halt_req  in  1  request to stop fetching.
- resume  in  1  leave the halted state.
- fetch_is_rvc  in  1  current fetched instruction is 16-bit; used only with PC_RVC_EN.
- fetch_ready  in  1  instruction memory accepts the request this cycle.
- fetch_valid  out  1  fetch request valid.
- fetch_pc  out  XLEN  fetch address; equals current_pc.
- current_pc  out  XLEN  registered PC.
- halted  out  1  high while in HALT.
- misalign  out  1  one-cycle pulse: an accepted target was misaligned.

## Operation
- States: BOOT, RUN, HALT.
- Reset (any time, including mid-stall or mid-halt):
  - pc = RESET_PC, state = BOOT, pend_valid = 0, misalign = 0.
  - fetch_valid = 0, halted = 0.
- BOOT:
  - fetch_valid = 0.
  - Unconditionally goes to RUN next cycle; pc unchanged.
- RUN:
  - fetch_valid = 1.
  - hold = (|stall) | ~fetch_ready.
  - Per-cycle update, in priority order:
    1. trap_valid: pc <= trap_vec; pend_valid <= 0. Applies regardless of hold.
    2. hold with redirect_valid: pend_pc <= redirect_pc, pend_valid <= 1. A newer redirect overwrites an older pending one. pc holds.
    3. hold without redirect_valid: pc holds.
    4. ~hold with redirect_valid: pc <= redirect_pc; pend_valid <= 0. A live redirect beats a pending one.
    5. ~hold with pend_valid: pc <= pend_pc; pend_valid <= 0.
    6. Otherwise: pc <= pc + INC.
  - halt_req while ~hold: the update above is applied, then state <= HALT.
  - halt_req while hold: ignored that cycle. The requester keeps it asserted.
  - trap_valid together with halt_req: trap is taken and the state stays RUN.
- HALT:
  - fetch_valid = 0, halted = 1, pc holds.
  - redirect_valid is captured into pend_pc/pend_valid.
  - trap_valid: pc <= trap_vec, pend cleared, state <= RUN.
  - resume: state <= RUN; the first RUN cycle fetches pc. Pending is consumed on the first non-held RUN cycle.
- Arithmetic and alignment:
  - INC = 4; pc + INC wraps modulo 2^XLEN.
  - Targets (redirect, pending, trap) are loaded with the low 2 bits forced to 0.
  - misalign pulses the cycle after such a target is loaded into pc if its original low 2 bits were nonzero.

## Timing
- Every output is registered or decoded from registered state; no input-to-output combinational path except none.
- Redirect/trap latency: applied at the edge they are sampled; fetch_pc shows the target in the next cycle.
- A redirect captured during a stall appears on fetch_pc one cycle after the first cycle in which hold is low.
- After reset deassertion: 1 BOOT cycle, then fetch_valid = 1 with fetch_pc = RESET_PC.
- halt_req accepted at edge N: fetch_valid = 0 from cycle N+1.
- resume at edge M: fetch_valid = 1 from cycle M+1.

## Configuration
- PC_RVC_EN defined:
  - INC = fetch_is_rvc ? 2 : 4.
  - Targets force only bit 0 to 0.
  - misalign pulses only if bit 0 of the original target was set.
- PC_RVC_EN undefined:
  - fetch_is_rvc is ignored; INC = 4.
  - 4-byte alignment rules above apply.

## Test plan
- Reset with RESET_PC=32'h100, no stalls, fetch_ready=1: fetch_valid low 1 cycle, then fetch_pc sequence 100, 104, 108.
- stall[1]=1 for 3 cycles at pc=104, with redirect_valid pulsed to 32'h200 in the 2nd stalled cycle: fetch_pc stays 104 for 3 cycles, then shows 200, then 204.
- Same cycle: trap_valid with trap_vec=32'h80, redirect_valid to 32'h300, stall[0]=1: next fetch_pc = 80, pending cleared.
- halt_req at pc=108, then resume 4 cycles later: fetch_valid low for 4 cycles, halted high, next fetch_pc = 10C.
- redirect to 32'h202: fetch_pc = 200 and misalign pulses once. With PC_RVC_EN: fetch_pc = 202, no pulse; then fetch_is_rvc=1 gives 204.
- pc at 32'hFFFF_FFFC, free-running: next fetch_pc = 0. Reset asserted mid-stall with pending valid: pending cleared, fetch_pc = RESET_PC after BOOT.
